// File: rtl/dac_serializer.sv
// dac_serializer: I2S mono serializer slaved to codec bclk/daclrck, all in clk_50 domain.
// Ports:
//   clk_50     system clock (50 MHz)
//   ar         asynchronous active-low reset
//   bclk       codec bit clock, sampled as data
//   daclrck    codec DAC LR clock, sampled as data (low = left, high = right)
//   sample_in  sample word, captured on each daclrck falling edge
//   mute       transmit zeros from the next captured frame onward
//   dacdat     serial data to codec, updated after detected bclk falls
//   sample_req one-cycle pulse when a frame is captured
//   frame_cnt  wrapping count of captured frames
// Option: DACSER_OFFSET_BIN_EN treats sample_in as offset binary (MSB inverted at capture).
module dac_serializer #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_50,
   input  logic             ar,
   input  logic             bclk,
   input  logic             daclrck,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             mute,
   output logic             dacdat,
   output logic             sample_req,
   output logic [7:0]       frame_cnt
);
   localparam int BW = $clog2(WIDTH + 1);

   logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync;
   logic                   r_bclk_prev, r_lrck_prev, r_lrck_last;
   logic [WIDTH-1:0]       r_hold, r_shreg;
   logic [BW-1:0]          r_bits_left;
   logic                   r_dacdat, r_sample_req;
   logic [7:0]             r_frame_cnt;
   logic                   w_bclk, w_lrck, w_bclk_fall, w_lrck_fall, w_slot_start;
   logic [WIDTH-1:0]       w_conv, w_cap, w_hold_next;

   assign w_bclk       = r_bclk_sync[SYNC_STAGES-1];
   assign w_lrck       = r_lrck_sync[SYNC_STAGES-1];
   assign w_bclk_fall  = r_bclk_prev & ~w_bclk;
   assign w_lrck_fall  = r_lrck_prev & ~w_lrck;
   assign w_slot_start = w_bclk_fall & (w_lrck != r_lrck_last);

`ifdef DACSER_OFFSET_BIN_EN
   assign w_conv = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
`else
   assign w_conv = sample_in;
`endif
   assign w_cap = mute ? '0 : w_conv;
   // A slot start coinciding with the frame capture must see the fresh word, not the stale hold.
   assign w_hold_next = w_lrck_fall ? w_cap : r_hold;

   assign dacdat     = r_dacdat;
   assign sample_req = r_sample_req;
   assign frame_cnt  = r_frame_cnt;

   always_ff @(posedge clk_50 or negedge ar) begin
      if (!ar) begin
         r_bclk_sync <= '0;
         r_lrck_sync <= '0;
         r_bclk_prev <= 1'b0;
         r_lrck_prev <= 1'b0;
      end else begin
         r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bclk};
         r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], daclrck};
         r_bclk_prev <= w_bclk;
         r_lrck_prev <= w_lrck;
      end
   end

   always_ff @(posedge clk_50 or negedge ar) begin
      if (!ar) begin
         r_hold       <= '0;
         r_sample_req <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_hold       <= w_hold_next;
         r_sample_req <= w_lrck_fall;
         r_frame_cnt  <= w_lrck_fall ? r_frame_cnt + 8'd1 : r_frame_cnt;
      end
   end

   // Slot start leaves dacdat untouched: that is the I2S one-bit delay before the MSB.
   always_ff @(posedge clk_50 or negedge ar) begin
      if (!ar) begin
         r_lrck_last <= 1'b0;
         r_shreg     <= '0;
         r_bits_left <= '0;
         r_dacdat    <= 1'b0;
      end else if (w_bclk_fall) begin
         r_lrck_last <= w_lrck;
         if (w_slot_start) begin
            r_shreg     <= w_hold_next;
            r_bits_left <= BW'(WIDTH);
         end else if (r_bits_left != '0) begin
            r_dacdat    <= r_shreg[WIDTH-1];
            r_shreg     <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bits_left <= r_bits_left - 1'b1;
         end else begin
            r_dacdat    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dac_serializer.sv
// tb_dac_serializer: directed scoreboard bench for dac_serializer (I2S mono serializer).
module tb_dac_serializer;
   logic        clk_50 = 1'b0;
   logic        ar = 1'b0;
   logic        bclk = 1'b1;
   logic        daclrck = 1'b1;
   logic [15:0] sample_in = '0;
   logic        mute = 1'b0;
   logic        dacdat, sample_req;
   logic [7:0]  frame_cnt;

   int checks = 0, errors = 0;
   int req_cnt = 0, wide_cnt = 0, exp_req = 0, exp_frames = 0;
   logic req_prev = 1'b0;
   logic exp_q[$];
   logic last_exp = 1'b0;
   logic [15:0] cur = '0;

   dac_serializer #(.WIDTH(16), .SYNC_STAGES(2)) dut (
      .clk_50(clk_50), .ar(ar), .bclk(bclk), .daclrck(daclrck),
      .sample_in(sample_in), .mute(mute), .dacdat(dacdat),
      .sample_req(sample_req), .frame_cnt(frame_cnt)
   );

   always #10 clk_50 = ~clk_50;

   always @(negedge clk_50) begin
      if (sample_req) req_cnt++;
      if (sample_req && req_prev) wide_cnt++;
      req_prev = sample_req;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] capture(input logic [15:0] s, input logic m);
      logic [15:0] v;
      v = s;
`ifdef DACSER_OFFSET_BIN_EN
      v[15] = ~v[15];
`endif
      return m ? 16'h0000 : v;
   endfunction

   // Expected dacdat per bclk fall of one slot: hold, then MSB..LSB, then zeros.
   task automatic push_slot(input logic [15:0] w, input int n);
      for (int k = 1; k <= n; k++) begin
         if (k == 1) exp_q.push_back(last_exp);
         else if (k <= 17) exp_q.push_back(w[17-k]);
         else exp_q.push_back(1'b0);
      end
      last_exp = exp_q[$];
   endtask

   task automatic falls(input logic lr, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_50);
         daclrck = lr;
         bclk = 1'b0;
         repeat (7) @(posedge clk_50);
         #5;
         if (exp_q.size() == 0) chk("queue_empty", 16'd1, 16'd0);
         else chk("dacdat", {15'd0, dacdat}, {15'd0, exp_q.pop_front()});
         @(negedge clk_50);
         bclk = 1'b1;
         repeat (7) @(negedge clk_50);
      end
   endtask

   task automatic start_frame();
      cur = capture(sample_in, mute);
      exp_frames++;
      exp_req++;
   endtask

   task automatic frame(input int n);
      start_frame();
      push_slot(cur, n);
      falls(1'b0, n);
      push_slot(cur, n);
      falls(1'b1, n);
   endtask

   task automatic chk_frame_state();
      chk("frame_cnt", {8'd0, frame_cnt}, 16'(exp_frames[7:0]));
      chk("sample_req_count", 16'(req_cnt), 16'(exp_req));
   endtask

   initial begin
      repeat (5) @(negedge clk_50);
      ar = 1'b1;
      repeat (5) @(negedge clk_50);
      chk("reset_dacdat", {15'd0, dacdat}, 16'd0);
      chk("reset_sample_req", {15'd0, sample_req}, 16'd0);
      chk("reset_frame_cnt", {8'd0, frame_cnt}, 16'd0);
      push_slot(16'h0000, 4);
      falls(1'b1, 4);

      sample_in = 16'hA5F0;
      frame(32);
      chk_frame_state();

      start_frame();
      push_slot(cur, 32);
      falls(1'b0, 5);
      sample_in = 16'h1234;
      falls(1'b0, 27);
      push_slot(cur, 32);
      falls(1'b1, 32);
      chk_frame_state();
      frame(32);
      chk_frame_state();

      start_frame();
      push_slot(cur, 32);
      falls(1'b0, 6);
      mute = 1'b1;
      falls(1'b0, 26);
      push_slot(cur, 32);
      falls(1'b1, 32);
      frame(32);
      chk_frame_state();
      mute = 1'b0;
      sample_in = 16'h8000;
      frame(32);
      chk_frame_state();

      sample_in = 16'hFFFF;
      frame(12);
      frame(12);
      frame(32);
      chk_frame_state();

      sample_in = 16'hA5F0;
      start_frame();
      push_slot(cur, 32);
      falls(1'b0, 7);
      @(negedge clk_50);
      ar = 1'b0;
      #1;
      chk("async_reset_dacdat", {15'd0, dacdat}, 16'd0);
      chk("async_reset_frame_cnt", {8'd0, frame_cnt}, 16'd0);
      exp_q.delete();
      last_exp = 1'b0;
      exp_frames = 0;
      repeat (3) @(negedge clk_50);
      ar = 1'b1;
      push_slot(16'h0000, 25);
      falls(1'b0, 25);
      push_slot(16'h0000, 32);
      falls(1'b1, 32);
      frame(32);
      chk_frame_state();
      chk("sample_req_width", 16'(wide_cnt), 16'd0);
      chk("queue_drained", 16'(exp_q.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
